// File: rtl/decode_fetch_queue.sv
// Instruction buffer feeding the decode format-scan stage: stamps each accepted
// fetch word with a major ID, queues it, and issues one word per cycle.
module decode_fetch_queue #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int queueDepth              = 8,
    parameter int queueIndexWidth         = 3
) (
    input  logic                               clock_i,
    input  logic                               resetn_i,
    input  logic                               fetchEnable_i,
    input  logic [instructionWidth-1:0]        fetchInstruction_i,
    input  logic [addressWidth-1:0]            fetchAddress_i,
    input  logic [PidSize-1:0]                 fetchPid_i,
    input  logic [TidSize-1:0]                 fetchTid_i,
    input  logic                               flush_i,
    input  logic                               stall_i,
    output logic                               full_o,
    output logic                               empty_o,
    output logic [queueIndexWidth:0]           occupancy_o,
    output logic                               overflow_o,
    output logic                               outputEnable_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o
);

    localparam logic [queueIndexWidth:0] depth_count = (queueIndexWidth+1)'(queueDepth);

    logic [queueIndexWidth-1:0]         head;
    logic [queueIndexWidth-1:0]         tail;
    logic [queueIndexWidth:0]           count;
    logic [instructionCounterWidth-1:0] maj_id;

    logic [instructionWidth-1:0]        mem_instr [queueDepth];
    logic [addressWidth-1:0]            mem_addr  [queueDepth];
    logic [PidSize-1:0]                 mem_pid   [queueDepth];
    logic [TidSize-1:0]                 mem_tid   [queueDepth];
    logic [instructionCounterWidth-1:0] mem_id    [queueDepth];

    logic push;
    logic pop;

    assign full_o      = (count == depth_count);
    assign empty_o     = (count == '0);
    assign occupancy_o = count;

    // Push is judged against the registered full flag, so a same-edge pop never frees room.
    assign push = fetchEnable_i && !full_o && !flush_i;
    assign pop  = !stall_i && !empty_o && !flush_i;

    // Storage carries no reset; entries are only read once written.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_instr[tail] <= fetchInstruction_i;
            mem_addr[tail]  <= fetchAddress_i;
            mem_pid[tail]   <= fetchPid_i;
            mem_tid[tail]   <= fetchTid_i;
            mem_id[tail]    <= maj_id;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            maj_id               <= '0;
            overflow_o           <= 1'b0;
            outputEnable_o       <= 1'b0;
            instruction_o        <= '0;
            instructionAddress_o <= '0;
            instructionPid_o     <= '0;
            instructionTid_o     <= '0;
            instructionMajId_o   <= '0;
        end else begin
            overflow_o <= fetchEnable_i && full_o && !flush_i;
            if (flush_i) begin
                // The ID counter survives a flush so IDs stay unique across redirects.
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                outputEnable_o <= 1'b0;
            end else begin
                if (push) begin
                    tail   <= tail + 1'b1;
                    maj_id <= maj_id + 1'b1;
                end
                if (pop) begin
                    head                 <= head + 1'b1;
                    outputEnable_o       <= 1'b1;
                    instruction_o        <= mem_instr[head];
                    instructionAddress_o <= mem_addr[head];
                    instructionPid_o     <= mem_pid[head];
                    instructionTid_o     <= mem_tid[head];
                    instructionMajId_o   <= mem_id[head];
                end else if (!stall_i) begin
                    outputEnable_o <= 1'b0;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode_fetch_queue.sv
// Directed bench for decode_fetch_queue: basic flow, fill/overflow, stall hold,
// pointer wrap, flush and asynchronous reset.
module tb_decode_fetch_queue;

    logic        clock_i = 1'b0;
    logic        resetn_i;
    logic        fetchEnable_i;
    logic [31:0] fetchInstruction_i;
    logic [63:0] fetchAddress_i;
    logic [19:0] fetchPid_i;
    logic [15:0] fetchTid_i;
    logic        flush_i;
    logic        stall_i;
    logic        full_o;
    logic        empty_o;
    logic [3:0]  occupancy_o;
    logic        overflow_o;
    logic        outputEnable_o;
    logic [31:0] instruction_o;
    logic [63:0] instructionAddress_o;
    logic [19:0] instructionPid_o;
    logic [15:0] instructionTid_o;
    logic [63:0] instructionMajId_o;

    int checks   = 0;
    int failures = 0;

    decode_fetch_queue dut (
        .clock_i(clock_i),
        .resetn_i(resetn_i),
        .fetchEnable_i(fetchEnable_i),
        .fetchInstruction_i(fetchInstruction_i),
        .fetchAddress_i(fetchAddress_i),
        .fetchPid_i(fetchPid_i),
        .fetchTid_i(fetchTid_i),
        .flush_i(flush_i),
        .stall_i(stall_i),
        .full_o(full_o),
        .empty_o(empty_o),
        .occupancy_o(occupancy_o),
        .overflow_o(overflow_o),
        .outputEnable_o(outputEnable_o),
        .instruction_o(instruction_o),
        .instructionAddress_o(instructionAddress_o),
        .instructionPid_o(instructionPid_o),
        .instructionTid_o(instructionTid_o),
        .instructionMajId_o(instructionMajId_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [19:0] pid_of(input logic [63:0] addr);
        return addr[19:0] ^ 20'h5A5A5;
    endfunction

    function automatic logic [15:0] tid_of(input logic [63:0] addr);
        return addr[17:2];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] instr, input logic [63:0] addr,
                           input logic [63:0] id);
        chk({tag, "_oe"}, 64'(outputEnable_o), 64'd1);
        chk({tag, "_instr"}, 64'(instruction_o), 64'(instr));
        chk({tag, "_addr"}, instructionAddress_o, addr);
        chk({tag, "_pid"}, 64'(instructionPid_o), 64'(pid_of(addr)));
        chk({tag, "_tid"}, 64'(instructionTid_o), 64'(tid_of(addr)));
        chk({tag, "_id"}, instructionMajId_o, id);
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [63:0] addr);
        fetchEnable_i      = 1'b1;
        fetchInstruction_i = instr;
        fetchAddress_i     = addr;
        fetchPid_i         = pid_of(addr);
        fetchTid_i         = tid_of(addr);
    endtask

    task automatic idle_fetch();
        fetchEnable_i = 1'b0;
    endtask

    // Asserts reset between edges, then releases it on the next falling edge.
    task automatic pulse_reset();
        #2 resetn_i = 1'b0;
        #1;
        @(negedge clock_i);
        resetn_i = 1'b1;
    endtask

    initial begin
        resetn_i = 1'b0;
        fetchEnable_i = 1'b0;
        fetchInstruction_i = '0;
        fetchAddress_i = '0;
        fetchPid_i = '0;
        fetchTid_i = '0;
        flush_i = 1'b0;
        stall_i = 1'b0;
        #1;
        chk("rst_oe", 64'(outputEnable_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_occ", 64'(occupancy_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_id", instructionMajId_o, 64'd0);
        chk("rst_instr", 64'(instruction_o), 64'd0);
        repeat (2) @(negedge clock_i);
        resetn_i = 1'b1;

        // Basic flow
        drive(32'h38000001, 64'h1000);
        tick();
        chk("basic_oe0", 64'(outputEnable_o), 64'd0);
        chk("basic_occ0", 64'(occupancy_o), 64'd1);
        drive(32'h38000002, 64'h1004);
        tick();
        chk_out("basic_w0", 32'h38000001, 64'h1000, 64'd0);
        drive(32'h38000003, 64'h1008);
        tick();
        chk_out("basic_w1", 32'h38000002, 64'h1004, 64'd1);
        idle_fetch();
        tick();
        chk_out("basic_w2", 32'h38000003, 64'h1008, 64'd2);
        chk("basic_empty", 64'(empty_o), 64'd1);
        tick();
        chk("basic_idle_oe", 64'(outputEnable_o), 64'd0);
        chk("basic_idle_hold", 64'(instruction_o), 64'h38000003);

        // Fill and overflow
        pulse_reset();
        stall_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            drive(32'h39000000 + 32'(k), 64'h3000 + 64'(4 * k));
            tick();
            chk("fill_occ", 64'(occupancy_o), (k < 8) ? 64'(k + 1) : 64'd8);
            chk("fill_full", 64'(full_o), (k >= 7) ? 64'd1 : 64'd0);
            chk("fill_ovf", 64'(overflow_o), (k == 8) ? 64'd1 : 64'd0);
            chk("fill_oe", 64'(outputEnable_o), 64'd0);
        end
        idle_fetch();
        stall_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out("drain", 32'h39000000 + 32'(i), 64'h3000 + 64'(4 * i), 64'(i));
            chk("drain_occ", 64'(occupancy_o), 64'(7 - i));
            if (i == 0) chk("ovf_pulse_end", 64'(overflow_o), 64'd0);
        end
        tick();
        chk("drain_empty", 64'(empty_o), 64'd1);
        chk("drain_oe", 64'(outputEnable_o), 64'd0);

        // Stall hold
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            drive(32'h3A000000 + 32'(k), 64'h2000 + 64'(4 * k));
            tick();
        end
        idle_fetch();
        tick();
        chk_out("stall_pre", 32'h3A000004, 64'h2010, 64'd4);
        stall_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 2) drive(32'h3A000005 + 32'(c), 64'h2014 + 64'(4 * c));
            else idle_fetch();
            tick();
            chk_out("stall_hold", 32'h3A000004, 64'h2010, 64'd4);
        end
        chk("stall_occ", 64'(occupancy_o), 64'd2);
        stall_i = 1'b0;
        tick();
        chk_out("stall_w5", 32'h3A000005, 64'h2014, 64'd5);
        tick();
        chk_out("stall_w6", 32'h3A000006, 64'h2018, 64'd6);
        tick();
        chk("stall_after_oe", 64'(outputEnable_o), 64'd0);

        // Wrap-around at one word per cycle
        pulse_reset();
        for (int k = 0; k < 20; k++) begin
            drive(32'h3B000000 + 32'(k), 64'h4000 + 64'(4 * k));
            tick();
            chk("wrap_occ", 64'(occupancy_o), 64'd1);
            if (k > 0) chk_out("wrap", 32'h3B000000 + 32'(k - 1), 64'h4000 + 64'(4 * (k - 1)), 64'(k - 1));
        end
        idle_fetch();
        tick();
        chk_out("wrap_last", 32'h3B000013, 64'h404C, 64'd19);
        chk("wrap_empty", 64'(empty_o), 64'd1);

        // Flush
        pulse_reset();
        for (int k = 0; k < 10; k++) begin
            drive(32'h3C000000 + 32'(k), 64'h5000 + 64'(4 * k));
            tick();
        end
        idle_fetch();
        tick();
        chk_out("flush_pre", 32'h3C000009, 64'h5024, 64'd9);
        stall_i = 1'b1;
        for (int k = 10; k < 15; k++) begin
            drive(32'h3C000000 + 32'(k), 64'h5000 + 64'(4 * k));
            tick();
        end
        chk("flush_queued", 64'(occupancy_o), 64'd5);
        drive(32'h3CFFFFFF, 64'h5FF0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_occ", 64'(occupancy_o), 64'd0);
        chk("flush_oe", 64'(outputEnable_o), 64'd0);
        chk("flush_ovf", 64'(overflow_o), 64'd0);
        chk("flush_hold_id", instructionMajId_o, 64'd9);
        stall_i = 1'b0;
        drive(32'h3C00000F, 64'h5100);
        tick();
        chk("flush_push_occ", 64'(occupancy_o), 64'd1);
        idle_fetch();
        tick();
        chk_out("flush_next", 32'h3C00000F, 64'h5100, 64'd15);

        // Asynchronous reset mid-stream
        stall_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(32'h3D000000 + 32'(k), 64'h6000 + 64'(4 * k));
            tick();
        end
        idle_fetch();
        chk("areset_pre_occ", 64'(occupancy_o), 64'd4);
        chk("areset_pre_oe", 64'(outputEnable_o), 64'd1);
        #2 resetn_i = 1'b0;
        #1;
        chk("areset_oe", 64'(outputEnable_o), 64'd0);
        chk("areset_occ", 64'(occupancy_o), 64'd0);
        chk("areset_empty", 64'(empty_o), 64'd1);
        chk("areset_id", instructionMajId_o, 64'd0);
        chk("areset_instr", 64'(instruction_o), 64'd0);
        chk("areset_addr", instructionAddress_o, 64'd0);
        @(negedge clock_i);
        resetn_i = 1'b1;
        stall_i = 1'b0;
        drive(32'h3E000000, 64'h7000);
        tick();
        idle_fetch();
        tick();
        chk_out("areset_first", 32'h3E000000, 64'h7000, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
